// File: rtl/grostl_pkg.sv
// Shared types, MixBytes constants and GF(2^8) helpers for the Grostl datapath.
package grostl_pkg;

   typedef logic [7:0] byte_t;
   typedef byte_t [0:7] col_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } mb_state_t;

   localparam int unsigned MB_COEF [0:7] = '{2, 2, 3, 4, 5, 3, 5, 7};
   localparam byte_t       GF_POLY       = 8'h1B;

   function automatic byte_t xtime(input byte_t x);
      return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
   endfunction

   // Only the small coefficients of the circulant are needed, so build them from doublings.
   function automatic byte_t gf_mul_small(input byte_t x, input int unsigned coef);
      byte_t x2;
      byte_t x4;
      byte_t res;
      x2 = xtime(x);
      x4 = xtime(x2);
      case (coef)
         2:       res = x2;
         3:       res = x2 ^ x;
         4:       res = x4;
         5:       res = x4 ^ x;
         6:       res = x4 ^ x2;
         7:       res = x4 ^ x2 ^ x;
         default: res = x;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/grostl_mix_column.sv
// Combinational MixBytes of one 8-byte column with circ(02,02,03,04,05,03,05,07).
module grostl_mix_column
   import grostl_pkg::*;
(
   input  col_t din,
   output col_t dout
);

   always_comb begin
      byte_t acc;
      dout = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         acc = '0;
         for (int unsigned j = 0; j < 8; j++) begin
            acc = acc ^ gf_mul_small(din[j], MB_COEF[(j + 8 - i) % 8]);
         end
         dout[i] = acc;
      end
   end

endmodule

// File: rtl/grostl_mix_bytes_seq.sv
// Sequential MixBytes over a full Grostl state, LANES columns per cycle, in place.
module grostl_mix_bytes_seq
   import grostl_pkg::*;
#(
   parameter int unsigned NCOLS = 8,
   parameter int unsigned LANES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NCOLS*64-1:0]   din,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NCOLS*64-1:0]   dout
);

   if (!(NCOLS == 8 || NCOLS == 16)) begin : g_bad_ncols
      $error("grostl_mix_bytes_seq: NCOLS must be 8 or 16");
   end
   if (LANES == 0 || (NCOLS % LANES) != 0) begin : g_bad_lanes
      $error("grostl_mix_bytes_seq: LANES must divide NCOLS");
   end

   localparam int unsigned     CW   = $clog2(NCOLS);
   localparam logic [CW-1:0]   STEP = CW'(LANES);
   localparam logic [CW-1:0]   LAST = CW'(NCOLS - LANES);

   typedef col_t [0:NCOLS-1] state_t;

   mb_state_t     state;
   mb_state_t     state_nx;
   state_t        st;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          last_grp;
   col_t          lane_in  [LANES];
   col_t          lane_out [LANES];

   assign accept   = in_valid && in_ready;
   assign last_grp = (cnt == LAST);
   assign dout     = st;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam logic [CW-1:0] OFF = CW'(l);
      assign lane_in[l] = st[cnt + OFF];
      grostl_mix_column u_mix (
         .din  (lane_in[l]),
         .dout (lane_out[l])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (in_valid) state_nx = ST_BUSY;
         ST_BUSY: if (last_grp) state_nx = ST_DONE;
         ST_DONE: if (out_ready) state_nx = in_valid ? ST_BUSY : ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: in_ready = 1'b1;
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   // Accepting a state always wins; BUSY write-back only happens when nothing is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         st  <= '0;
         cnt <= '0;
      end else if (accept) begin
         st  <= state_t'(din);
         cnt <= '0;
      end else if (state == ST_BUSY) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            st[cnt + CW'(l)] <= lane_out[l];
         end
         cnt <= last_grp ? '0 : cnt + STEP;
      end
   end

endmodule

// File: tb/tb_grostl_mix_bytes_seq.sv
// Directed checks of grostl_mix_bytes_seq in three configurations against a shift-and-add GF model.
module tb_grostl_mix_bytes_seq;

   typedef logic [0:7][7:0]             tcol_t;
   typedef logic [0:7][0:7][7:0]        st8_t;
   typedef logic [0:15][0:7][7:0]       st16_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic  a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0;
   st8_t  a_din = '0, a_dout;
   logic  b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0;
   st16_t b_din = '0, b_dout;
   logic  c_iv = 1'b0, c_ir, c_ov, c_or = 1'b0;
   st8_t  c_din = '0, c_dout;

   grostl_mix_bytes_seq #(.NCOLS(8), .LANES(1)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .din(a_din),
      .out_valid(a_ov), .out_ready(a_or), .dout(a_dout));

   grostl_mix_bytes_seq #(.NCOLS(16), .LANES(4)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .din(b_din),
      .out_valid(b_ov), .out_ready(b_or), .dout(b_dout));

   grostl_mix_bytes_seq #(.NCOLS(8), .LANES(8)) u_c (
      .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .din(c_din),
      .out_valid(c_ov), .out_ready(c_or), .dout(c_dout));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   function automatic tcol_t ref_col(input tcol_t c);
      logic [7:0] coef [0:7] = '{8'h02, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03, 8'h05, 8'h07};
      tcol_t o;
      o = '0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            o[i] = o[i] ^ gmul(c[j], coef[(j - i + 8) % 8]);
      return o;
   endfunction

   function automatic st8_t ref8(input st8_t s);
      st8_t o;
      for (int c = 0; c < 8; c++) o[c] = ref_col(s[c]);
      return o;
   endfunction

   function automatic st8_t rnd8();
      st8_t s;
      for (int c = 0; c < 8; c++)
         for (int r = 0; r < 8; r++) s[c][r] = 8'($urandom);
      return s;
   endfunction

   // Call at a negedge with the engine able to accept (IDLE, or DONE with a_or raised).
   task automatic a_send(input st8_t d, output int lat);
      a_din = d;
      a_iv  = 1'b1;
      @(negedge clk);
      a_iv = 1'b0;
      a_or = 1'b0;
      chk("a_busy_ready", a_ir, 1'b0);
      lat = 0;
      while (!a_ov && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic a_release();
      a_or = 1'b1;
      @(negedge clk);
      a_or = 1'b0;
   endtask

   task automatic b_send(input st16_t d, output int lat);
      b_din = d;
      b_iv  = 1'b1;
      @(negedge clk);
      b_iv = 1'b0;
      lat  = 0;
      while (!b_ov && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      st8_t  d, d2, e;
      st16_t s16;
      st8_t  cs [0:4];
      int    lat;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", a_ir, 1'b1);
      chk("rst_out_valid", a_ov, 1'b0);
      chk("rst_dout", a_dout, '0);

      // unit vector in column 0 row 0
      d = '0;
      d[0][0] = 8'h01;
      a_send(d, lat);
      chk("unit_latency", lat, 8);
      e = '0;
      e[0] = 64'h02070503_05040302;
      chk("unit_dout", a_dout, e);
      chk("unit_done_ready", a_ir, 1'b0);
      a_release();
      chk("idle_out_valid", a_ov, 1'b0);
      chk("idle_in_ready", a_ir, 1'b1);

      d = {64{8'h01}};
      a_send(d, lat);
      chk("ones_latency", lat, 8);
      chk("ones_dout", a_dout, {64{8'h03}});
      a_release();

      // reduction path: 0x80 in row 0
      d = '0;
      d[0][0] = 8'h80;
      a_send(d, lat);
      e = '0;
      e[0] = 64'h1BADB69B_B6369B1B;
      chk("x80_dout", a_dout, e);
      a_release();

      // DONE held with out_ready low, then back-to-back accept
      d = rnd8();
      a_send(d, lat);
      repeat (10) @(negedge clk);
      chk("hold_out_valid", a_ov, 1'b1);
      chk("hold_in_ready", a_ir, 1'b0);
      chk("hold_dout", a_dout, ref8(d));
      d2 = rnd8();
      a_or = 1'b1;
      a_send(d2, lat);
      chk("b2b_latency", lat, 8);
      chk("b2b_dout", a_dout, ref8(d2));
      a_release();

      // reset while BUSY with counter at 3
      d = rnd8();
      a_din = d;
      a_iv  = 1'b1;
      @(negedge clk);
      a_iv = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_out_valid", a_ov, 1'b0);
      chk("midrst_in_ready", a_ir, 1'b1);
      @(negedge clk);
      chk("midrst_stay_idle", a_ov, 1'b0);
      d = rnd8();
      a_send(d, lat);
      chk("postrst_latency", lat, 8);
      chk("postrst_dout", a_dout, ref8(d));
      a_release();

      // NCOLS=16, LANES=4
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 16; c++)
            for (int r = 0; r < 8; r++) s16[c][r] = 8'($urandom);
         b_send(s16, lat);
         chk("b_latency", lat, 4);
         for (int c = 0; c < 16; c++) chk($sformatf("b_col%0d", c), b_dout[c], ref_col(s16[c]));
         b_or = 1'b1;
         @(negedge clk);
         b_or = 1'b0;
      end

      // LANES=NCOLS=8 streaming: one result every two cycles
      for (int k = 0; k < 5; k++) cs[k] = rnd8();
      c_or  = 1'b1;
      c_din = cs[0];
      c_iv  = 1'b1;
      @(negedge clk);
      chk("c_busy_valid", c_ov, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("c_done_valid", c_ov, 1'b1);
         chk($sformatf("c_dout%0d", k), c_dout, ref8(cs[k]));
         c_din = cs[k + 1];
         if (k == 3) c_iv = 1'b0;
         @(negedge clk);
         chk("c_gap_valid", c_ov, 1'b0);
      end
      chk("c_final_ready", c_ir, 1'b1);
      c_or = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
